// File: rtl/motoro3_step_sequencer.sv
// Commutation step sequencer feeding sgStep/m3cnt timing to the 3-phase PWM generator.
// Optional reverse stepping via `define M3_STEP_REVERSE_EN (adds dirRev input).
module motoro3_step_sequencer #(
  parameter int CNT_W     = 25,
  parameter int STEP_LAST = 11,
  parameter int MIN_LEN   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic [CNT_W-1:0] m3r_stepLen,
  input  logic [3:0]       m3r_startStep,
`ifdef M3_STEP_REVERSE_EN
  input  logic             dirRev,
`endif
  output logic             pwmActive1,
  output logic [3:0]       sgStep,
  output logic [CNT_W-1:0] m3cnt,
  output logic             m3cntFirst1,
  output logic             m3cntFirst2,
  output logic             m3cntLast1,
  output logic             m3cntLast2,
  output logic             stepDone,
  output logic [15:0]      revCnt,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, ARM, RUN, DRAIN} state_t;

  localparam logic [CNT_W-1:0] MIN_LEN_C   = CNT_W'(MIN_LEN);
  localparam logic [3:0]       STEP_LAST_C = 4'(STEP_LAST);

  state_t           state, stateNext;
  logic             armCnt, armCntNext;
  logic             stopPend, stopPendNext;
  logic [CNT_W-1:0] lenCur, lenNext, lenClamped, lenM1, lenM2, cntNext;
  logic [3:0]       stepNext, stepAdv;
  logic [15:0]      revNext;
  logic             wrap, goRev, stepEnd, runNow;

`ifdef M3_STEP_REVERSE_EN
  assign goRev = dirRev;
`else
  assign goRev = 1'b0;
`endif

  assign lenClamped = (m3r_stepLen < MIN_LEN_C) ? MIN_LEN_C : m3r_stepLen;
  assign lenM1      = lenCur - CNT_W'(1);
  assign lenM2      = lenCur - CNT_W'(2);
  assign runNow     = (state == RUN);
  assign stepEnd    = runNow && (m3cnt == lenM1);

  assign m3cntFirst1 = runNow && (m3cnt == '0);
  assign m3cntFirst2 = runNow && (m3cnt == CNT_W'(1));
  assign m3cntLast2  = runNow && (m3cnt == lenM2);
  assign m3cntLast1  = runNow && (m3cnt == lenM1);
  assign busy        = (state != IDLE);

  always_comb begin
    stepAdv = sgStep + 4'd1;
    wrap    = 1'b0;
    if (goRev) begin
      if (sgStep == 4'd0) begin
        stepAdv = STEP_LAST_C;
        wrap    = 1'b1;
      end else begin
        stepAdv = sgStep - 4'd1;
      end
    end else if (sgStep >= STEP_LAST_C) begin
      stepAdv = 4'd0;
      wrap    = 1'b1;
    end
  end

  always_comb begin
    stateNext    = state;
    armCntNext   = armCnt;
    stopPendNext = stopPend;
    cntNext      = m3cnt;
    stepNext     = sgStep;
    lenNext      = lenCur;
    revNext      = revCnt;
    case (state)
      IDLE: begin
        cntNext      = '0;
        stopPendNext = 1'b0;
        if (start && !stop) begin
          stateNext  = ARM;
          armCntNext = 1'b0;
          lenNext    = lenClamped;
          stepNext   = (m3r_startStep > STEP_LAST_C) ? 4'd0 : m3r_startStep;
        end
      end
      ARM: begin
        cntNext = '0;
        if (stop)        stateNext = IDLE;
        else if (armCnt) stateNext = RUN;
        else             armCntNext = 1'b1;
      end
      RUN: begin
        if (stop) stopPendNext = 1'b1;
        if (stepEnd) begin
          cntNext = '0;
          // a stop arriving on the final cycle still lets this step finish, then drains
          if (stopPend || stop) begin
            stateNext    = DRAIN;
            stopPendNext = 1'b0;
          end else begin
            stepNext = stepAdv;
            lenNext  = lenClamped;
            if (wrap) revNext = revCnt + 16'd1;
          end
        end else begin
          cntNext = m3cnt + CNT_W'(1);
        end
      end
      DRAIN: begin
        cntNext      = '0;
        stopPendNext = 1'b0;
        stateNext    = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  // registered strobes are computed from next-state values so they align with m3cnt
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      armCnt     <= 1'b0;
      stopPend   <= 1'b0;
      m3cnt      <= '0;
      sgStep     <= 4'd0;
      lenCur     <= MIN_LEN_C;
      revCnt     <= '0;
      pwmActive1 <= 1'b0;
      stepDone   <= 1'b0;
    end else begin
      state      <= stateNext;
      armCnt     <= armCntNext;
      stopPend   <= stopPendNext;
      m3cnt      <= cntNext;
      sgStep     <= stepNext;
      lenCur     <= lenNext;
      revCnt     <= revNext;
      pwmActive1 <= (stateNext == RUN);
      stepDone   <= (stateNext == RUN) && (cntNext == lenNext - CNT_W'(1));
    end
  end

endmodule

// File: tb/tb_motoro3_step_sequencer.sv
// Directed bench for motoro3_step_sequencer with a per-cycle expectation scoreboard.
module tb_motoro3_step_sequencer;

  logic        clk = 1'b0;
  logic        rst, start, stop;
  logic [24:0] m3r_stepLen;
  logic [3:0]  m3r_startStep;
  logic        dirRev;
  logic        pwmActive1, m3cntFirst1, m3cntFirst2, m3cntLast1, m3cntLast2;
  logic        stepDone, busy;
  logic [3:0]  sgStep;
  logic [24:0] m3cnt;
  logic [15:0] revCnt;

  always #5 clk = ~clk;

  motoro3_step_sequencer #(.CNT_W(25), .STEP_LAST(11), .MIN_LEN(16)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
    .m3r_stepLen(m3r_stepLen), .m3r_startStep(m3r_startStep),
`ifdef M3_STEP_REVERSE_EN
    .dirRev(dirRev),
`endif
    .pwmActive1(pwmActive1), .sgStep(sgStep), .m3cnt(m3cnt),
    .m3cntFirst1(m3cntFirst1), .m3cntFirst2(m3cntFirst2),
    .m3cntLast1(m3cntLast1), .m3cntLast2(m3cntLast2),
    .stepDone(stepDone), .revCnt(revCnt), .busy(busy)
  );

  typedef struct {
    string       tag;
    logic        pwm;
    logic [3:0]  stp;
    logic [24:0] cnt;
    logic [3:0]  strb;
    logic        done;
    logic [15:0] rev;
    logic        busy;
  } exp_t;

  exp_t expQ[$];
  int   nChecks = 0;
  int   nFail   = 0;
  int   mStep, mRev;

  task automatic chk(input string tag, input string name, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s.%s observed=%0h expected=%0h", tag, name, obs, exp);
    end
  endtask

  task automatic pushExp(input string tag, input logic pwm, input int stp, input int cnt,
                         input logic [3:0] strb, input logic done, input int rev, input logic bsy);
    exp_t e;
    e.tag = tag; e.pwm = pwm; e.stp = 4'(stp); e.cnt = 25'(cnt);
    e.strb = strb; e.done = done; e.rev = 16'(rev); e.busy = bsy;
    expQ.push_back(e);
  endtask

  // Spec model of RUN: ncyc cycles from m3cnt=0, constant requested length.
  task automatic pushRun(input string tag, input int st, input int len, input int ncyc, input bit rev);
    int eff, c;
    eff = (len < 16) ? 16 : len;
    c = 0;
    mStep = (st > 11) ? 0 : st;
    for (int i = 0; i < ncyc; i++) begin
      pushExp(tag, 1'b1, mStep, c, {c == 0, c == 1, c == eff - 2, c == eff - 1}, c == eff - 1, mRev, 1'b1);
      c++;
      if (c == eff) begin
        c = 0;
        if (!rev) begin
          if (mStep == 11) begin mStep = 0; mRev = (mRev + 1) & 16'hFFFF; end
          else mStep++;
        end else begin
          if (mStep == 0) begin mStep = 11; mRev = (mRev + 1) & 16'hFFFF; end
          else mStep--;
        end
      end
    end
  endtask

  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    if (expQ.size() > 0) begin
      e = expQ.pop_front();
      chk(e.tag, "pwmActive1", 32'(pwmActive1), 32'(e.pwm));
      chk(e.tag, "sgStep", 32'(sgStep), 32'(e.stp));
      chk(e.tag, "m3cnt", 32'(m3cnt), 32'(e.cnt));
      chk(e.tag, "strobes", 32'({m3cntFirst1, m3cntFirst2, m3cntLast2, m3cntLast1}), 32'(e.strb));
      chk(e.tag, "stepDone", 32'(stepDone), 32'(e.done));
      chk(e.tag, "revCnt", 32'(revCnt), 32'(e.rev));
      chk(e.tag, "busy", 32'(busy), 32'(e.busy));
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic doReset(input string tag);
    rst = 1'b1;
    mRev = 0;
    pushExp(tag, 1'b0, 0, 0, 4'b0000, 1'b0, 0, 1'b0);
    tick();
    rst = 1'b0;
  endtask

  task automatic doStart(input string tag, input int len, input int st);
    m3r_stepLen = 25'(len);
    m3r_startStep = 4'(st);
    start = 1'b1;
    pushExp(tag, 1'b0, (st > 11) ? 0 : st, 0, 4'b0000, 1'b0, mRev, 1'b1);
    pushExp(tag, 1'b0, (st > 11) ? 0 : st, 0, 4'b0000, 1'b0, mRev, 1'b1);
    tick();
    start = 1'b0;
    tick();
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; stop = 1'b0; dirRev = 1'b0;
    m3r_stepLen = '0; m3r_startStep = '0;
    mRev = 0; mStep = 0;

    doReset("reset");

    // basic step of length 20, then reset mid-RUN at m3cnt=7 of step 1
    doStart("arm20", 20, 0);
    pushRun("len20", 0, 20, 28, 1'b0);
    ticks(28);
    doReset("rstMidRun");

    // clamp to 16; length change mid-step applies at next step only
    doStart("arm5", 5, 3);
    pushRun("clamp16", 3, 5, 16, 1'b0);
    tick();
    m3r_stepLen = 25'd40;
    ticks(15);
    pushRun("len40", 4, 40, 3, 1'b0);
    ticks(3);
    doReset("rstClamp");

    // twelve steps from step 10: revolution count on 11->0
    doStart("arm12", 16, 10);
    pushRun("rev12", 10, 16, 12 * 16 + 1, 1'b0);
    ticks(12 * 16 + 1);
    doReset("rstRev");

    // stop at m3cnt=3 of step 4; second stop and a start while busy are ignored
    doStart("armStop", 32, 4);
    pushRun("stopStep", 4, 32, 32, 1'b0);
    pushExp("drain", 1'b0, 4, 0, 4'b0000, 1'b0, 0, 1'b1);
    pushExp("idleHold", 1'b0, 4, 0, 4'b0000, 1'b0, 0, 1'b0);
    pushExp("idleHold", 1'b0, 4, 0, 4'b0000, 1'b0, 0, 1'b0);
    ticks(4);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    ticks(6);
    stop = 1'b1; start = 1'b1;
    tick();
    stop = 1'b0; start = 1'b0;
    ticks(21 + 3);

    // start and stop together in IDLE: stays idle
    start = 1'b1; stop = 1'b1;
    pushExp("startStop", 1'b0, 4, 0, 4'b0000, 1'b0, 0, 1'b0);
    tick();
    start = 1'b0; stop = 1'b0;
    pushExp("startStop2", 1'b0, 4, 0, 4'b0000, 1'b0, 0, 1'b0);
    tick();

    // out-of-range start step maps to 0; stop during ARM returns to IDLE
    m3r_startStep = 4'd14; m3r_stepLen = 25'd16;
    start = 1'b1;
    pushExp("armAbort", 1'b0, 0, 0, 4'b0000, 1'b0, 0, 1'b1);
    tick();
    start = 1'b0; stop = 1'b1;
    pushExp("armAbortIdle", 1'b0, 0, 0, 4'b0000, 1'b0, 0, 1'b0);
    tick();
    stop = 1'b0;

`ifdef M3_STEP_REVERSE_EN
    doReset("rstDir");
    dirRev = 1'b1;
    doStart("armRev", 16, 1);
    pushRun("reverse", 1, 16, 3 * 16 + 1, 1'b1);
    ticks(3 * 16 + 1);
    dirRev = 1'b0;
`endif

    nChecks++;
    assert (expQ.size() == 0) else begin
      nFail++;
      $error("FAIL scoreboardDrain observed=%0d expected=0", expQ.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule

// File: doc/motoro3_step_sequencer.md
Name: motoro3_step_sequencer

Overview:
- Commutation step sequencer for the 3-phase PWM generator.
- Drives the timing inputs of the PWM generator: `sgStep` (0..11), the step-position counter `m3cnt`, the `m3cntFirst*` / `m3cntLast*` boundary strobes, and `pwmActive1`.
- Handles start/stop sequencing, per-step length latching and electrical-revolution counting.
- Sits between the register file (`m3r_*` configuration) and the PWM generator.

Parameters:
- CNT_W, 25, width of `m3cnt` and of the step length.
- STEP_LAST, 11, last `sgStep` value before wrap to 0.
- MIN_LEN, 16, minimum effective step length in clk cycles.

Ports:
- clk  input  1  system clock, 10 MHz.
- rst  input  1  synchronous active-high reset.
- start  input  1  one-cycle pulse; requests run.
- stop  input  1  one-cycle pulse; requests orderly stop.
- m3r_stepLen  input  CNT_W  requested step length in clk cycles.
- m3r_startStep  input  4  `sgStep` value for the first step after start.
- pwmActive1  output  1  high while steps are being executed.
- sgStep  output  4  current commutation step.
- m3cnt  output  CNT_W  cycle index within the current step.
- m3cntFirst1  output  1  high when `m3cnt`==0 in RUN.
- m3cntFirst2  output  1  high when `m3cnt`==1 in RUN.
- m3cntLast1  output  1  high when `m3cnt`==lenCur-1 in RUN.
- m3cntLast2  output  1  high when `m3cnt`==lenCur-2 in RUN.
- stepDone  output  1  one-cycle pulse on the last cycle of every step.
- revCnt  output  16  completed electrical revolutions (step 11 to 0 wraps).
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (synchronous, rst=1 sampled at posedge clk), reset values:
  - state=IDLE, pwmActive1=0, sgStep=0, m3cnt=0, revCnt=0, lenCur=MIN_LEN.
  - All strobes 0; busy=0.
  - Reset mid-RUN aborts immediately, with no step completion.
- States:
  - IDLE: waits for start.
  - ARM: exactly 2 cycles, pwmActive1=0. Latches lenCur=max(m3r_stepLen, MIN_LEN) and sgStep=m3r_startStep. If m3r_startStep>STEP_LAST, sgStep=0.
  - RUN: `m3cnt` increments by 1 per cycle from 0. pwmActive1=1 from the first RUN cycle.
  - DRAIN: entered when a stop request is pending at a step end. One cycle, pwmActive1=0, m3cnt=0, then IDLE.
- IDLE to ARM: on start=1 and stop=0. In ARM, start is ignored; stop returns to IDLE.
- Step end in RUN, when `m3cnt`==lenCur-1:
  - stepDone=1.
  - Next cycle: m3cnt=0 and sgStep advances (STEP_LAST wraps to 0).
  - lenCur re-latched from m3r_stepLen with the MIN_LEN clamp. m3r_stepLen changes mid-step take effect only at the next step.
  - revCnt increments on the 11 to 0 wrap; wraps 0xFFFF to 0.
- Strobes:
  - Decoded combinationally from the registered `m3cnt`/lenCur, and gated by RUN.
  - Because lenCur>=16, First1/First2/Last2/Last1 are always distinct cycles, in that order within a step.
- Stop handling:
  - stop in RUN sets stopPend. The current step completes fully, including Last2, Last1 and stepDone. The state then goes to DRAIN instead of advancing.
  - sgStep holds its last value through DRAIN/IDLE.
  - start while busy is ignored.
  - start and stop in the same cycle: stop wins, start dropped.
  - A second stop while stopPend is set has no further effect.
- All outputs are registered except the four `m3cnt*` strobes and busy.

Optional Feature:
- Macro: M3_STEP_REVERSE_EN.
- When defined:
  - Adds input port `dirRev` (1 bit), sampled at each step end.
  - dirRev=1 makes sgStep decrement, with 0 wrapping to STEP_LAST.
  - revCnt increments on the 0 to 11 wrap.
  - dirRev changes mid-step apply at the next step end only.
- When undefined: no `dirRev` port; sgStep always increments.

Test Plan:
- Reset, then start with m3r_stepLen=20, m3r_startStep=0:
  - ARM holds 2 cycles with pwmActive1=0.
  - Then m3cnt counts 0..19; First1@0, First2@1, Last2@18, Last1@19.
  - sgStep goes 0 to 1 at cycle 20.
- m3r_stepLen=5 → effective length 16; Last1 at m3cnt=15.
- Run 12 steps from m3r_startStep=10 with length 16:
  - sgStep sequence 10,11,0,...,9.
  - revCnt goes 0 to 1 exactly at the 11 to 0 transition.
- stop pulsed at m3cnt=3 of step 4 (len 32):
  - Step 4 completes to m3cnt=31 with Last2/Last1/stepDone.
  - Then DRAIN one cycle, then IDLE; sgStep holds 4, pwmActive1=0.
- start and stop together in IDLE → remains IDLE. rst asserted mid-RUN at m3cnt=7 → all outputs are at reset values the next cycle.
- With M3_STEP_REVERSE_EN, dirRev=1, m3r_startStep=1, len 16:
  - sgStep goes 1, 0, 11.
  - revCnt increments at the 0 to 11 transition.
